// File: rtl/unidade_acesso_dados.sv
// unidade_acesso_dados: byte-burst load/store unit between a CPU and a data memory
// with registered reads.
//   clock, reset_n            : rising-edge clock, asynchronous active-low reset
//   req, escrita, endereco,
//   comprimento               : burst request (write/read, start address, length; 0 = 16)
//   dado_wr, dado_wr_valido,
//   dado_wr_pronto            : write-byte handshake, one byte per beat
//   dado_rd, dado_rd_valido   : read byte and its one-cycle pulse
//   ocupado, concluido, erro  : busy, end-of-transaction pulse, last request out of range
//   mem_write, mem_endereco,
//   mem_dado_in, mem_dado_out : data memory port
module unidade_acesso_dados #(
  parameter logic [7:0] BASE = 8'd128,
  parameter logic [7:0] TOPO = 8'd223
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       escrita,
  input  logic [7:0] endereco,
  input  logic [3:0] comprimento,
  input  logic [7:0] dado_wr,
  input  logic       dado_wr_valido,
  output logic       dado_wr_pronto,
  output logic [7:0] dado_rd,
  output logic       dado_rd_valido,
  output logic       ocupado,
  output logic       concluido,
  output logic       erro,
  output logic       mem_write,
  output logic [7:0] mem_endereco,
  output logic [7:0] mem_dado_in,
  input  logic [7:0] mem_dado_out
);
  typedef enum logic [2:0] {OCIOSO, ESPERA_DADO, ESCREVE, LE_END, LE_CAP, FIM} estado_t;
  estado_t    state_q, state_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] rest_q, rest_d;
  logic       erro_q, erro_d, rd_valid_q;
  logic [8:0] end_final;
  logic       em_faixa, ultimo;
  // End address in 9 bits so a burst running past 255 is caught instead of wrapping.
  assign end_final = {1'b0, endereco} + {4'b0, comprimento == 4'd0, comprimento} - 9'd1;
  assign em_faixa  = (endereco >= BASE) && (end_final <= {1'b0, TOPO});
  // rest_q counts beats left after the current one, so 0 marks the last beat.
  assign ultimo    = rest_q == 4'd0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCIOSO;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      rest_q     <= 4'd0;
      erro_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rest_q     <= rest_d;
      erro_q     <= erro_d;
      rd_valid_q <= state_q == LE_CAP;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rest_d  = rest_q;
    erro_d  = erro_q;
    case (state_q)
      OCIOSO: if (req) begin
        erro_d  = !em_faixa;
        state_d = !em_faixa ? FIM : (escrita ? ESPERA_DADO : LE_END);
        if (em_faixa) begin
          addr_d = endereco;
          rest_d = comprimento - 4'd1;
        end
      end
      ESPERA_DADO: if (dado_wr_valido) begin
        wdata_d = dado_wr;
        state_d = ESCREVE;
      end
      ESCREVE: begin
        state_d = ultimo ? FIM : ESPERA_DADO;
        addr_d  = ultimo ? addr_q : addr_q + 8'd1;
        rest_d  = ultimo ? rest_q : rest_q - 4'd1;
      end
      LE_END: state_d = LE_CAP;
      LE_CAP: begin
        rdata_d = mem_dado_out;
        state_d = ultimo ? FIM : LE_END;
        addr_d  = ultimo ? addr_q : addr_q + 8'd1;
        rest_d  = ultimo ? rest_q : rest_q - 4'd1;
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end
  assign dado_wr_pronto = state_q == ESPERA_DADO;
  assign mem_write      = state_q == ESCREVE;
  assign ocupado        = state_q != OCIOSO;
  assign concluido      = state_q == FIM;
  assign erro           = erro_q;
  assign mem_endereco   = addr_q;
  assign mem_dado_in    = wdata_q;
  assign dado_rd        = rdata_q;
  assign dado_rd_valido = rd_valid_q;
endmodule
